// File: rtl/nor_logic_unit_if.sv
// Operand/result bundle of the NOR logic unit.
// master: the block that issues operations and consumes results.
// slave: the logic unit itself.
interface nor_logic_unit_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             fault_inj;
    logic             clear_count;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] ref_s;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, op, a, b, fault_inj, clear_count,
        input  out_valid, s, ref_s, mismatch, err_count
    );

    modport slave (
        input  in_valid, op, a, b, fault_inj, clear_count,
        output out_valid, s, ref_s, mismatch, err_count
    );
endinterface

// File: rtl/nor_logic_unit.sv
// Two-stage, two-operand logic unit. The result is computed twice: once by
// a network made only of 2-input NOR gates, once by plain expressions. The
// two results are compared on every valid operation. A saturating counter
// records how often they disagree.
module nor_logic_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    nor_logic_unit_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // Bitwise 2-input NOR: the only gate the NOR path is built from.
    function automatic logic [WIDTH-1:0] nor2(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        return ~(x | y);
    endfunction

    // Stage-1 registers
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             fault_r;
    logic             v1_r;

    // Gate-level network: every node is one NOR per bit
    logic [WIDTH-1:0] inv_a_s;
    logic [WIDTH-1:0] inv_b_s;
    logic [WIDTH-1:0] nor_ab_s;
    logic [WIDTH-1:0] or_ab_s;
    logic [WIDTH-1:0] and_ab_s;
    logic [WIDTH-1:0] nand_ab_s;
    logic [WIDTH-1:0] x_g2_s;
    logic [WIDTH-1:0] x_g3_s;
    logic [WIDTH-1:0] xnor_ab_s;
    logic [WIDTH-1:0] xor_ab_s;
    logic [WIDTH-1:0] andn_ab_s;

    assign inv_a_s   = nor2(a_r, a_r);
    assign inv_b_s   = nor2(b_r, b_r);
    assign nor_ab_s  = nor2(a_r, b_r);
    assign or_ab_s   = nor2(nor_ab_s, nor_ab_s);
    assign and_ab_s  = nor2(inv_a_s, inv_b_s);
    assign nand_ab_s = nor2(and_ab_s, and_ab_s);
    // x_g2 = ~a&b, x_g3 = a&~b; their NOR is XNOR, one more inverter gives XOR
    assign x_g2_s    = nor2(a_r, nor_ab_s);
    assign x_g3_s    = nor2(b_r, nor_ab_s);
    assign xnor_ab_s = nor2(x_g2_s, x_g3_s);
    assign xor_ab_s  = nor2(xnor_ab_s, xnor_ab_s);
    assign andn_ab_s = nor2(inv_a_s, b_r);

    // Reference expressions
    logic [WIDTH-1:0] ref_not_s;
    logic [WIDTH-1:0] ref_or_s;
    logic [WIDTH-1:0] ref_nor_s;
    logic [WIDTH-1:0] ref_and_s;
    logic [WIDTH-1:0] ref_nand_s;
    logic [WIDTH-1:0] ref_xor_s;
    logic [WIDTH-1:0] ref_xnor_s;
    logic [WIDTH-1:0] ref_andn_s;

    assign ref_not_s  = ~a_r;
    assign ref_or_s   = a_r | b_r;
    assign ref_nor_s  = ~(a_r | b_r);
    assign ref_and_s  = a_r & b_r;
    assign ref_nand_s = ~(a_r & b_r);
    assign ref_xor_s  = a_r ^ b_r;
    assign ref_xnor_s = ~(a_r ^ b_r);
    assign ref_andn_s = a_r & ~b_r;

    logic [WIDTH-1:0] nor_res_s;
    logic [WIDTH-1:0] ref_res_s;
    logic [WIDTH-1:0] nor_fault_s;
    logic             mismatch_s;

    // Op select for both paths, fault insertion on bit 0, and comparison
    always_comb begin
        nor_res_s = {WIDTH{1'b0}};
        ref_res_s = {WIDTH{1'b0}};
        case (op_r)
            3'b000: begin nor_res_s = inv_a_s;   ref_res_s = ref_not_s;  end
            3'b001: begin nor_res_s = or_ab_s;   ref_res_s = ref_or_s;   end
            3'b010: begin nor_res_s = nor_ab_s;  ref_res_s = ref_nor_s;  end
            3'b011: begin nor_res_s = and_ab_s;  ref_res_s = ref_and_s;  end
            3'b100: begin nor_res_s = nand_ab_s; ref_res_s = ref_nand_s; end
            3'b101: begin nor_res_s = xor_ab_s;  ref_res_s = ref_xor_s;  end
            3'b110: begin nor_res_s = xnor_ab_s; ref_res_s = ref_xnor_s; end
            3'b111: begin nor_res_s = andn_ab_s; ref_res_s = ref_andn_s; end
            default: begin nor_res_s = {WIDTH{1'b0}}; ref_res_s = {WIDTH{1'b0}}; end
        endcase
        nor_fault_s = nor_res_s;
        if (fault_r) begin
            nor_fault_s[0] = ~nor_res_s[0];
        end else begin
            nor_fault_s[0] = nor_res_s[0];
        end
        mismatch_s = (nor_fault_s != ref_res_s);
    end

    // Stage 1: capture operands on in_valid, otherwise hold them and drop v1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            op_r    <= 3'b000;
            fault_r <= 1'b0;
            v1_r    <= 1'b0;
        end else begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                a_r     <= bus.a;
                b_r     <= bus.b;
                op_r    <= bus.op;
                fault_r <= bus.fault_inj;
            end
        end
    end

    // Stage 2: register both results and their comparison when stage 1 is valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.s         <= {WIDTH{1'b0}};
            bus.ref_s     <= {WIDTH{1'b0}};
            bus.mismatch  <= 1'b0;
        end else begin
            bus.out_valid <= v1_r;
            if (v1_r) begin
                bus.s        <= nor_fault_s;
                bus.ref_s    <= ref_res_s;
                bus.mismatch <= mismatch_s;
            end
        end
    end

    // Saturating mismatch counter; clear wins over a same-edge increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err_count <= {CNT_W{1'b0}};
        end else if (bus.clear_count) begin
            bus.err_count <= {CNT_W{1'b0}};
        end else if (v1_r && mismatch_s && (bus.err_count != CNT_MAX)) begin
            bus.err_count <= bus.err_count + CNT_ONE;
        end
    end

endmodule

// File: doc/nor_logic_unit.md
# nor_logic_unit

Parametrised, pipelined two-operand logic unit. Every function is built only from two-input NOR gates, and an expression-based reference model of the same function runs in parallel. The unit compares the two results on each valid operation and keeps a saturating mismatch count. It is the vector-width, multi-function, clocked successor of the team's single-bit NOR gate exercises and serves as a self-checking gate-level datapath.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (at least 1)
- CNT_W, 8, width of the mismatch counter (at least 1)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  operands and op are sampled this cycle
- op  input  3  function select (see Operation)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- fault_inj  input  1  when high at sampling, bit 0 of the NOR-path result is inverted (verification aid)
- clear_count  input  1  synchronous clear of err_count
- out_valid  output  1  s, ref_s and mismatch are valid this cycle
- s  output  WIDTH  NOR-network result
- ref_s  output  WIDTH  expression-model result
- mismatch  output  1  s differs from ref_s (qualified by out_valid)
- err_count  output  CNT_W  saturating count of mismatching valid results

## Operation
Op encoding, applied bitwise:
- 000 ~a
- 001 a|b
- 010 ~(a|b)
- 011 a&b
- 100 ~(a&b)
- 101 a^b
- 110 ~(a^b)
- 111 a&~b

NOR path:
- Each function is a network of 2-input NOR primitives only.
- Inversion is nor(x,x).
- AND is nor(~a,~b).
- XOR uses a NOR-only construction, e.g. the 5-gate form.
- The op mux is behavioural.

Reference path:
- Plain continuous-assignment expressions.

Pipeline:
- Stage 1 (input register): on a clk edge with in_valid=1, capture a, b, op and fault_inj and set v1=1. With in_valid=0, set v1=0 and hold a, b, op.
- Stage 2 (output register): on each edge, out_valid<=v1. When v1=1:
  - s <= NOR result, with bit 0 inverted if the captured fault_inj=1
  - ref_s <= reference result
  - mismatch <= (NOR result != ref result)
- When v1=0, s, ref_s and mismatch hold their values.

Counter:
- On an edge where v1=1, the mismatch condition is true and err_count is below 2^CNT_W-1, err_count increments by 1.
- At 2^CNT_W-1 the counter saturates and does not wrap.
- clear_count=1 forces err_count to 0 on that edge. It has priority over a simultaneous increment.

Reset values: out_valid=0, s=0, ref_s=0, mismatch=0, err_count=0, v1=0, stage-1 registers 0.

Reset mid-operation: an in-flight operation in stage 1 is discarded, and no out_valid pulse follows reset release.

## Timing
- Latency: 2 cycles. Inputs sampled at edge N appear on the outputs after edge N+1.
- Throughput: 1 operation per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Bubbles: an in_valid gap of k cycles produces an out_valid gap of k cycles, 2 cycles later.
- There is no backpressure; the consumer must accept every out_valid cycle.
- err_count updates on the same edge that raises out_valid for the mismatching result.
- Asynchronous reset takes effect immediately, independent of clk. Release is sampled on the next rising edge.

## Test plan
- Reset then idle: assert reset mid-cycle with in_valid=1 -> all outputs 0 immediately; out_valid stays 0 for 3 cycles after release with in_valid=0.
- Functional sweep, WIDTH=4: op=010, a=0101, b=0011 -> s=ref_s=1000 two edges later. op=101, a=1100, b=1010 -> 0110. op=111, a=1100, b=1010 -> 0100. op=000, a=0110 -> 1001. mismatch=0 and err_count=0 throughout.
- Streaming: 8 back-to-back ops, then a 2-cycle in_valid gap, then 2 ops -> out_valid pattern 11111111 00 11, shifted by 2 cycles, with results in order.
- Fault injection: op=011, a=1111, b=1111, fault_inj=1 -> s=1110, ref_s=1111, mismatch=1, err_count=1.
- Saturation and clear, CNT_W=2: 5 consecutive faulted ops -> err_count goes 1, 2, 3, 3, 3. Then clear_count=1 in the same cycle as a faulted result -> err_count=0.
- Exhaustive: WIDTH=2, all 8 ops × 16 a/b pairs -> s equals ref_s for every case, and err_count=0.
